dispense_scheduler: RTL

- Shares one dispense motor among NUM_LANES VendingMachine instances. Each instance's dispense output is a lane request.
- Each rising edge of a lane's request queues one vend for that lane, held in a per-lane saturating pending counter.
- A round-robin arbiter grants the motor to one lane at a time. The motor runs for MOTOR_CYCLES, followed by a GAP_CYCLES cooldown.
- Sits between the per-lane VendingMachine outputs and the motor driver.

---
 rtl/dispense_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dispense_scheduler.sv
// rtl/dispense_scheduler.sv - round-robin scheduler sharing one dispense motor across vending lanes
// Optional DISPENSE_SCHEDULER_STATS_EN adds the totalVends output counter.
module dispense_scheduler #(
  parameter int NUM_LANES    = 4,
  parameter int MOTOR_CYCLES = 20,
  parameter int GAP_CYCLES   = 5,
  parameter int PEND_W       = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_LANES-1:0]         dispenseReq,
  input  logic [NUM_LANES-1:0]         laneEnable,
  output logic                         motorOn,
  output logic [$clog2(NUM_LANES)-1:0] motorSel,
  output logic                         vendDone,
  output logic                         pendingAny,
  output logic [NUM_LANES-1:0]         overflow
`ifdef DISPENSE_SCHEDULER_STATS_EN
  ,
  output logic [15:0]                  totalVends
`endif
);

  localparam int SEL_W   = $clog2(NUM_LANES);
  localparam int TMR_MAX = (MOTOR_CYCLES > GAP_CYCLES) ? MOTOR_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [TMR_W-1:0]  MOTOR_LOAD = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SPIN, GAP} state_t;

  state_t               state, state_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [SEL_W-1:0]     last_grant, grant_lane, sel_nxt;
  logic                 grant_ok, do_grant, motor_nxt, done_nxt, any_nxt;
  logic [NUM_LANES-1:0] prev_req, req_det, eligible, dec, ovf_nxt;
  logic [PEND_W-1:0]    pending  [NUM_LANES];
  logic [PEND_W-1:0]    pend_nxt [NUM_LANES];
  logic [SEL_W-1:0]     cand;
  int                   idx;

  assign req_det = dispenseReq & ~prev_req;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      eligible[i] = (pending[i] != '0) && laneEnable[i];
    end
  end

  // Search starts one past the last grant so every enabled lane gets a turn.
  always_comb begin
    grant_ok   = 1'b0;
    grant_lane = '0;
    idx        = 0;
    cand       = '0;
    for (int off = 0; off < NUM_LANES; off++) begin
      idx  = (int'(last_grant) + 1 + off) % NUM_LANES;
      cand = SEL_W'(idx);
      if (!grant_ok && eligible[cand]) begin
        grant_ok   = 1'b1;
        grant_lane = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    motor_nxt = motorOn;
    sel_nxt   = motorSel;
    done_nxt  = 1'b0;
    do_grant  = 1'b0;
    case (state)
      IDLE: do_grant = grant_ok;
      SPIN: begin
        if (timer == '0) begin
          motor_nxt = 1'b0;
          done_nxt  = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            timer_nxt = GAP_LOAD;
          end
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      GAP: begin
        // The last cooldown cycle arbitrates directly, so the motor is off exactly GAP_CYCLES cycles.
        if (timer == '0) begin
          state_nxt = IDLE;
          do_grant  = grant_ok;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_grant) begin
      state_nxt = SPIN;
      motor_nxt = 1'b1;
      sel_nxt   = grant_lane;
      timer_nxt = MOTOR_LOAD;
    end
  end

  // A request and a grant on the same lane in one cycle cancel out.
  always_comb begin
    any_nxt = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dec[i]      = do_grant && (grant_lane == SEL_W'(i));
      pend_nxt[i] = pending[i];
      ovf_nxt[i]  = overflow[i];
      if (req_det[i] && !dec[i]) begin
        if (pending[i] == PEND_MAX) begin
          ovf_nxt[i] = 1'b1;
        end else begin
          pend_nxt[i] = pending[i] + PEND_W'(1);
        end
      end else if (!req_det[i] && dec[i]) begin
        pend_nxt[i] = pending[i] - PEND_W'(1);
      end
      any_nxt = any_nxt | (pend_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      motorOn    <= 1'b0;
      motorSel   <= '0;
      vendDone   <= 1'b0;
      pendingAny <= 1'b0;
      overflow   <= '0;
      prev_req   <= '0;
      last_grant <= SEL_W'(NUM_LANES - 1);
      for (int i = 0; i < NUM_LANES; i++) begin
        pending[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      motorOn    <= motor_nxt;
      motorSel   <= sel_nxt;
      vendDone   <= done_nxt;
      pendingAny <= any_nxt;
      overflow   <= ovf_nxt;
      prev_req   <= dispenseReq;
      if (do_grant) begin
        last_grant <= grant_lane;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        pending[i] <= pend_nxt[i];
      end
    end
  end

`ifdef DISPENSE_SCHEDULER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      totalVends <= '0;
    end else if (done_nxt) begin
      totalVends <= totalVends + 16'd1;
    end
  end
`endif

endmodule
